// File: rtl/dcm_prog_pkg.sv
// Shared constants for the multi-DCM CLKGEN programming controller: FSM encodings,
// slot counts and the D/M command headers shifted ahead of each value.
package dcm_prog_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_LD_D      = 3'd1;
  localparam state_t ST_GAP1      = 3'd2;
  localparam state_t ST_LD_M      = 3'd3;
  localparam state_t ST_GAP2      = 3'd4;
  localparam state_t ST_GO        = 3'd5;
  localparam state_t ST_WAIT_DONE = 3'd6;
  localparam state_t ST_RST       = 3'd7;

  localparam int unsigned HDR_SLOTS = 2;
  localparam int unsigned GAP_SLOTS = 2;
  localparam int unsigned RST_HOLD  = 4;

  // Headers go out bit 0 first: D sends 1 then 0, M sends 1 then 1.
  localparam logic [1:0] HDR_D = 2'b01;
  localparam logic [1:0] HDR_M = 2'b11;

endpackage

// File: rtl/dcm_prog_ctrl_multi_if.sv
// Request side and shared DCM programming bus of the controller.
// master = controller, slave = command decoder / DCM side.
interface dcm_prog_ctrl_multi_if #(
  parameter int unsigned NUM_DCM = 2,
  parameter int unsigned CH_W    = 3,
  parameter int unsigned MD_W    = 8
);
  logic               clk_valid;
  logic               start;
  logic [CH_W-1:0]    ch;
  logic [MD_W-1:0]    speed_in;
  logic               busy;
  logic               done;
  logic               error;
  logic               progclk;
  logic               progdata;
  logic [NUM_DCM-1:0] progen;
  logic [NUM_DCM-1:0] dcm_reset;
  logic [NUM_DCM-1:0] locked;
  logic [NUM_DCM-1:0] progdone;

  modport master (
    input  clk_valid, start, ch, speed_in, locked, progdone,
    output busy, done, error, progclk, progdata, progen, dcm_reset
  );

  modport slave (
    output clk_valid, start, ch, speed_in, locked, progdone,
    input  busy, done, error, progclk, progdata, progen, dcm_reset
  );
endinterface

// File: rtl/dcm_lock_watchdog.sv
// Per-DCM lock watchdog: counts cycles spent unlocked and not being programmed,
// and emits a one-cycle reset pulse when the counter MSB would set.
module dcm_lock_watchdog #(
  parameter int unsigned WD_W = 24
) (
  input  logic clk,
  input  logic rst_n,
  input  logic locked,
  input  logic inhibit,
  output logic rst_pulse
);

  logic [WD_W-1:0] cnt_q, cnt_d;
  logic            pulse_q, pulse_d;

  always_comb begin
    cnt_d   = cnt_q + WD_W'(1);
    pulse_d = 1'b0;
    if (locked || inhibit) begin
      cnt_d = '0;
    end else if (cnt_d[WD_W-1]) begin
      cnt_d   = '0;
      pulse_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign rst_pulse = pulse_q;

endmodule

// File: rtl/dcm_prog_ctrl_multi.sv
// Serial D/M programmer for NUM_DCM DCM_CLKGEN instances on a shared PROGCLK/PROGDATA
// bus, with PROGDONE timeout, bounded retry and a per-DCM lock watchdog.
module dcm_prog_ctrl_multi
  import dcm_prog_pkg::*;
#(
  parameter int unsigned NUM_DCM     = 2,
  parameter int unsigned CH_W        = 3,
  parameter int unsigned OSC_MHZ     = 100,
  parameter int unsigned SPEED_MIN   = 25,
  parameter int unsigned SPEED_LIMIT = 100,
  parameter int unsigned MD_W        = 8,
  parameter int unsigned WD_W        = 24,
  parameter int unsigned DONE_TO_W   = 16,
  parameter int unsigned MAX_RETRY   = 3
) (
  input logic                  clk,
  input logic                  rst_n,
  dcm_prog_ctrl_multi_if.master bus
);

  localparam int unsigned FRAME_W = HDR_SLOTS + MD_W;
  localparam int unsigned CNT_MAX = (FRAME_W > RST_HOLD) ? FRAME_W : RST_HOLD;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX);
  localparam int unsigned RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [DONE_TO_W-1:0] to_cnt_q, to_cnt_d;
  logic [RETRY_W-1:0]   retry_q, retry_d;
  logic [CH_W-1:0]      ch_q, ch_d;
  logic [MD_W-1:0]      dsh_q, dsh_d, msh_q, msh_d;
  logic                 done_q, done_d;
  logic                 error_q, error_d;
  logic                 progclk_q;
  logic                 progdata_q, progdata_d;
  logic [NUM_DCM-1:0]   progen_q, progen_d;

  logic [NUM_DCM-1:0]   ch_sel;
  logic [NUM_DCM-1:0]   wd_pulse;
  logic [FRAME_W-1:0]   d_frame, m_frame;
  logic                 slot_edge;
  logic                 busy;
  logic                 bad_req;

  // Bus outputs may only move where PROGCLK falls, i.e. when progclk_q is high.
  assign slot_edge = progclk_q;
  assign busy      = (state_q != ST_IDLE);
  assign d_frame   = {dsh_q, HDR_D};
  assign m_frame   = {msh_q, HDR_M};
  assign bad_req   = (32'(bus.ch) >= NUM_DCM) ||
                     (bus.speed_in < MD_W'(SPEED_MIN)) ||
                     (bus.speed_in > MD_W'(SPEED_LIMIT));

  always_comb begin
    for (int i = 0; i < NUM_DCM; i++) begin
      ch_sel[i] = (ch_q == CH_W'(i));
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    to_cnt_d   = to_cnt_q;
    retry_d    = retry_q;
    ch_d       = ch_q;
    dsh_d      = dsh_q;
    msh_d      = msh_q;
    error_d    = error_q;
    done_d     = 1'b0;
    progen_d   = progen_q;
    progdata_d = progdata_q;
    if (slot_edge) begin
      progen_d   = '0;
      progdata_d = 1'b0;
    end

    if (!bus.clk_valid) begin
      state_d    = ST_IDLE;
      progen_d   = '0;
      progdata_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            if (bad_req) begin
              error_d = 1'b1;
            end else begin
              ch_d    = bus.ch;
              dsh_d   = MD_W'(OSC_MHZ - 1);
              msh_d   = bus.speed_in - MD_W'(1);
              error_d = 1'b0;
              retry_d = '0;
              cnt_d   = '0;
              state_d = ST_LD_D;
            end
          end
        end
        ST_LD_D, ST_LD_M: begin
          if (slot_edge) begin
            progen_d   = ch_sel;
            progdata_d = (state_q == ST_LD_D) ? d_frame[cnt_q] : m_frame[cnt_q];
            if (cnt_q == CNT_W'(FRAME_W - 1)) begin
              cnt_d   = '0;
              state_d = (state_q == ST_LD_D) ? ST_GAP1 : ST_GAP2;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        ST_GAP1, ST_GAP2: begin
          if (slot_edge) begin
            if (cnt_q == CNT_W'(GAP_SLOTS - 1)) begin
              cnt_d   = '0;
              state_d = (state_q == ST_GAP1) ? ST_LD_M : ST_GO;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        ST_GO: begin
          if (slot_edge) begin
            progen_d   = ch_sel;
            progdata_d = 1'b0;
            to_cnt_d   = '0;
            state_d    = ST_WAIT_DONE;
          end
        end
        ST_WAIT_DONE: begin
          if (|(bus.progdone & ch_sel)) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else if (&to_cnt_q) begin
            cnt_d   = '0;
            state_d = ST_RST;
          end else begin
            to_cnt_d = to_cnt_q + DONE_TO_W'(1);
          end
        end
        ST_RST: begin
          // Every timed-out attempt gets its reset hold, the final one included.
          if (cnt_q == CNT_W'(RST_HOLD - 1)) begin
            cnt_d = '0;
            if (retry_q == RETRY_W'(MAX_RETRY)) begin
              error_d = 1'b1;
              state_d = ST_IDLE;
            end else begin
              retry_d = retry_q + RETRY_W'(1);
              state_d = ST_LD_D;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      to_cnt_q   <= '0;
      retry_q    <= '0;
      ch_q       <= '0;
      dsh_q      <= '0;
      msh_q      <= '0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      progclk_q  <= 1'b0;
      progdata_q <= 1'b0;
      progen_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      to_cnt_q   <= to_cnt_d;
      retry_q    <= retry_d;
      ch_q       <= ch_d;
      dsh_q      <= dsh_d;
      msh_q      <= msh_d;
      done_q     <= done_d;
      error_q    <= error_d;
      progclk_q  <= ~progclk_q;
      progdata_q <= progdata_d;
      progen_q   <= progen_d;
    end
  end

  for (genvar i = 0; i < NUM_DCM; i++) begin : g_wd
    dcm_lock_watchdog #(
      .WD_W (WD_W)
    ) u_wd (
      .clk       (clk),
      .rst_n     (rst_n),
      .locked    (bus.locked[i]),
      .inhibit   (busy && ch_sel[i]),
      .rst_pulse (wd_pulse[i])
    );
  end

  assign bus.busy      = busy;
  assign bus.done      = done_q;
  assign bus.error     = error_q;
  assign bus.progclk   = progclk_q;
  assign bus.progdata  = progdata_q;
  assign bus.progen    = progen_q;
  assign bus.dcm_reset = wd_pulse | ((state_q == ST_RST) ? ch_sel : '0);

endmodule

// File: tb/tb_dcm_prog_ctrl_multi.sv
// Directed bench for dcm_prog_ctrl_multi: expected PROGCLK slots are queued at start
// and compared against the slots captured on each rising PROGCLK.
module tb_dcm_prog_ctrl_multi;

  localparam int unsigned NUM_DCM   = 2;
  localparam int unsigned CH_W      = 3;
  localparam int unsigned MD_W      = 8;
  localparam int unsigned WD_W      = 6;
  localparam int unsigned DONE_TO_W = 6;
  localparam int unsigned OSC_MHZ   = 100;
  localparam int unsigned FRAME_SLOTS = 2 * (2 + MD_W) + 1;

  typedef logic [NUM_DCM:0] slot_t;  // {progen, progdata}

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dcm_prog_ctrl_multi_if #(.NUM_DCM(NUM_DCM), .CH_W(CH_W), .MD_W(MD_W)) bus ();

  dcm_prog_ctrl_multi #(
    .NUM_DCM     (NUM_DCM),
    .CH_W        (CH_W),
    .OSC_MHZ     (OSC_MHZ),
    .SPEED_MIN   (25),
    .SPEED_LIMIT (100),
    .MD_W        (MD_W),
    .WD_W        (WD_W),
    .DONE_TO_W   (DONE_TO_W),
    .MAX_RETRY   (3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  slot_t exp_q[$];
  slot_t obs_q[$];
  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int rst_pulses[NUM_DCM] = '{default: 0};
  int rst_cyc[NUM_DCM] = '{default: 0};
  logic [NUM_DCM-1:0] rst_prev = '0;

  always @(negedge clk) begin
    if (bus.progclk && bus.progen != '0) obs_q.push_back({bus.progen, bus.progdata});
    if (bus.done) done_cnt <= done_cnt + 1;
    for (int i = 0; i < NUM_DCM; i++) begin
      if (bus.dcm_reset[i]) begin
        rst_cyc[i] <= rst_cyc[i] + 1;
        if (!rst_prev[i]) rst_pulses[i] <= rst_pulses[i] + 1;
      end
    end
    rst_prev <= bus.dcm_reset;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic push_frame(input int ch, input logic [MD_W-1:0] speed);
    logic [NUM_DCM-1:0] sel;
    logic [MD_W-1:0] dsh, msh;
    sel = '0;
    sel[ch] = 1'b1;
    dsh = MD_W'(OSC_MHZ - 1);
    msh = speed - MD_W'(1);
    exp_q.push_back({sel, 1'b1});
    exp_q.push_back({sel, 1'b0});
    for (int b = 0; b < MD_W; b++) exp_q.push_back({sel, dsh[b]});
    exp_q.push_back({sel, 1'b1});
    exp_q.push_back({sel, 1'b1});
    for (int b = 0; b < MD_W; b++) exp_q.push_back({sel, msh[b]});
    exp_q.push_back({sel, 1'b0});
  endtask

  task automatic compare_slots(input string tag, input int n);
    slot_t o, e;
    chk({tag, "_count"}, obs_q.size(), n);
    for (int i = 0; i < n && obs_q.size() > 0 && exp_q.size() > 0; i++) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      chk($sformatf("%s_slot%0d", tag, i), o, e);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic pulse_start(input int ch, input int speed);
    @(negedge clk);
    bus.ch = CH_W'(ch);
    bus.speed_in = MD_W'(speed);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_slots(input int n, input int bound);
    for (int i = 0; i < bound && obs_q.size() < n; i++) @(negedge clk);
  endtask

  task automatic wait_idle(input int bound);
    for (int i = 0; i < bound && bus.busy; i++) @(negedge clk);
  endtask

  task automatic run_prog(input int ch, input int speed, input bit unlock);
    int d0, p0;
    d0 = done_cnt;
    p0 = rst_pulses[ch];
    push_frame(ch, MD_W'(speed));
    pulse_start(ch, speed);
    chk("busy_after_start", bus.busy, 1);
    chk("error_cleared", bus.error, 0);
    if (unlock) bus.locked[ch] = 1'b0;
    wait_slots(FRAME_SLOTS, 400);
    chk("no_done_early", done_cnt - d0, 0);
    bus.progdone[ch] = 1'b1;
    if (unlock) bus.locked[ch] = 1'b1;
    wait_idle(20);
    bus.progdone[ch] = 1'b0;
    @(negedge clk);
    chk("done_pulse", done_cnt - d0, 1);
    chk("busy_low_after_done", bus.busy, 0);
    chk("no_reset_on_prog", rst_pulses[ch] - p0, 0);
    compare_slots($sformatf("frame_ch%0d_m%0d", ch, speed), FRAME_SLOTS);
  endtask

  task automatic reject(input string tag, input int ch, input int speed);
    logic any;
    any = 1'b0;
    pulse_start(ch, speed);
    repeat (4) begin
      any = any | bus.busy | (bus.progen != '0);
      @(negedge clk);
    end
    chk({tag, "_error"}, bus.error, 1);
    chk({tag, "_no_activity"}, any, 0);
    chk({tag, "_no_slots"}, obs_q.size(), 0);
    obs_q.delete();
  endtask

  initial begin
    int d0, p0, p1, c0, c1;
    logic pc_a;
    bus.clk_valid = 1'b1;
    bus.start = 1'b0;
    bus.ch = '0;
    bus.speed_in = '0;
    bus.locked = '1;
    bus.progdone = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_error", bus.error, 0);
    chk("rst_progclk", bus.progclk, 0);
    chk("rst_progen", bus.progen, 0);
    chk("rst_dcm_reset", bus.dcm_reset, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Main sequence: D=0x63, M=0x31 on channel 1
    run_prog(1, 50, 1'b0);

    // Rejected requests, then both speed boundaries accepted
    reject("speed_low", 1, 24);
    reject("speed_high", 1, 101);
    reject("bad_ch", 2, 50);
    run_prog(0, 25, 1'b0);
    run_prog(1, 100, 1'b0);

    // PROGDONE never arrives: four attempts, each with a 4-clk reset
    d0 = done_cnt; p1 = rst_pulses[1]; c1 = rst_cyc[1]; p0 = rst_pulses[0];
    for (int a = 0; a < 4; a++) push_frame(1, MD_W'(60));
    pulse_start(1, 60);
    wait_idle(3000);
    @(negedge clk);
    chk("retry_busy", bus.busy, 0);
    chk("retry_error", bus.error, 1);
    chk("retry_pulses", rst_pulses[1] - p1, 4);
    chk("retry_reset_cycles", rst_cyc[1] - c1, 16);
    chk("retry_no_done", done_cnt - d0, 0);
    chk("retry_other_ch_reset", rst_pulses[0] - p0, 0);
    compare_slots("retry", 4 * FRAME_SLOTS);

    // clk_valid drop during LD_M
    push_frame(1, MD_W'(40));
    pulse_start(1, 40);
    wait_slots(13, 200);
    bus.clk_valid = 1'b0;
    @(negedge clk);
    chk("cv_progen", bus.progen, 0);
    chk("cv_progdata", bus.progdata, 0);
    chk("cv_busy", bus.busy, 0);
    pc_a = bus.progclk;
    @(negedge clk);
    chk("cv_progclk_runs", pc_a ^ bus.progclk, 1);
    repeat (5) @(negedge clk);
    chk("cv_still_idle", bus.busy, 0);
    compare_slots("cv_abort", 13);
    bus.clk_valid = 1'b1;
    repeat (3) @(negedge clk);
    run_prog(1, 40, 1'b0);

    // Watchdog: exactly 2**(WD_W-1) unlocked cycles gives one pulse
    p0 = rst_pulses[0]; c0 = rst_cyc[0];
    @(negedge clk);
    bus.locked[0] = 1'b0;
    repeat (31) @(negedge clk);
    chk("wd_not_yet", bus.dcm_reset[0], 0);
    @(negedge clk);
    bus.locked[0] = 1'b1;
    repeat (3) @(negedge clk);
    chk("wd_pulses", rst_pulses[0] - p0, 1);
    chk("wd_pulse_width", rst_cyc[0] - c0, 1);

    // Watchdog inhibited while its DCM is programmed
    run_prog(0, 30, 1'b1);

    // Asynchronous reset clears sticky error
    reject("pre_reset", 1, 200);
    #2 rst_n = 1'b0;
    #1 chk("arst_error", bus.error, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Asynchronous reset mid-sequence
    pulse_start(1, 70);
    repeat (15) @(negedge clk);
    chk("arst_pre_busy", bus.busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", bus.busy, 0);
    chk("arst_progen", bus.progen, 0);
    chk("arst_progdata", bus.progdata, 0);
    chk("arst_progclk", bus.progclk, 0);
    chk("arst_done", bus.done, 0);
    chk("arst_dcm_reset", bus.dcm_reset, 0);
    @(negedge clk);
    rst_n = 1'b1;
    obs_q.delete();
    exp_q.delete();
    repeat (3) @(negedge clk);
    chk("post_arst_idle", bus.busy, 0);
    chk("post_arst_error", bus.error, 0);
    chk("post_arst_no_slots", obs_q.size(), 0);
    run_prog(0, 50, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
